// File: rtl/posit_add_arbiter.sv
// posit_add_arbiter
//   Shares one fixed-latency pipelined posit adder among NREQ requesters.
//   A round-robin arbiter issues at most one add per cycle. A shadow
//   pipeline tags each issued op, so each adder result is routed back to
//   the requester that issued it. A drain mode quiesces the adder. If the
//   adder's done strobe disagrees with the shadow pipeline, a sticky error
//   flag is raised.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        per-requester handshake (ready is one-hot, combinational)
//   req_in1/req_in2            packed operands, requester i at [i*DW +: DW]
//   add_in1/add_in2/add_start  registered adder inputs
//   add_result/inf/zero/done   adder outputs
//   rsp_valid                  one-hot response strobe (no backpressure)
//   rsp_result/inf/zero        shared response payload
//   drain/drained              quiesce request / quiesce complete
//   busy                       at least one op in flight
//   err_mismatch               sticky done-vs-shadow disagreement
module posit_add_arbiter #(
  parameter int NREQ    = 4,
  parameter int LATENCY = 8,
  parameter int DW      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_in1,
  input  logic [NREQ*DW-1:0] req_in2,
  output logic [NREQ-1:0]    req_ready,
  output logic [DW-1:0]      add_in1,
  output logic [DW-1:0]      add_in2,
  output logic               add_start,
  input  logic [DW-1:0]      add_result,
  input  logic               add_inf,
  input  logic               add_zero,
  input  logic               add_done,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_result,
  output logic               rsp_inf,
  output logic               rsp_zero,
  input  logic               drain,
  output logic               drained,
  output logic               busy,
  output logic               err_mismatch
);

  localparam int TAGW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW   = $clog2(LATENCY + 2);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DRAINED} state_t;
  state_t state_reg, state_next;

  // Unpacked views of the operand buses
  logic [DW-1:0] in1_arr [NREQ];
  logic [DW-1:0] in2_arr [NREQ];
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign in1_arr[gi] = req_in1[gi*DW +: DW];
      assign in2_arr[gi] = req_in2[gi*DW +: DW];
    end
  endgenerate

  logic [TAGW-1:0] rr_ptr_reg;
  logic [TAGW-1:0] start_tag_reg;
  logic [TAGW-1:0] grant_idx;
  logic            grant_any;
  logic [TAGW-1:0] cand;
  int              cand_wide;

  // Round-robin search: the first valid requester at or after the pointer.
  // Grants are only given in RUN.
  always_comb begin
    req_ready = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    cand_wide = 0;
    if (state_reg == ST_RUN) begin
      for (int k = 0; k < NREQ; k++) begin
        cand_wide = int'(rr_ptr_reg) + k;
        if (cand_wide >= NREQ) cand_wide = cand_wide - NREQ;
        cand = TAGW'(cand_wide);
        if (!grant_any && req_valid[cand]) begin
          grant_any = 1'b1;
          grant_idx = cand;
        end
      end
      if (grant_any) req_ready[grant_idx] = 1'b1;
    end
  end

  // Issue stage: capture the granted operands for the adder
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_start     <= 1'b0;
      add_in1       <= '0;
      add_in2       <= '0;
      start_tag_reg <= '0;
      rr_ptr_reg    <= '0;
    end else begin
      add_start <= grant_any;
      if (grant_any) begin
        add_in1       <= in1_arr[grant_idx];
        add_in2       <= in2_arr[grant_idx];
        start_tag_reg <= grant_idx;
        rr_ptr_reg    <= (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + TAGW'(1);
      end
    end
  end

  // The shadow pipeline runs in lockstep with the adder. Its head valid bit
  // is the add_done that we expect to see in the same cycle.
  logic [LATENCY-1:0]           shadow_valid;
  logic [LATENCY-1:0][TAGW-1:0] shadow_tag;
  logic                         head_valid;
  logic [TAGW-1:0]              head_tag;

  assign head_valid = shadow_valid[LATENCY-1];
  assign head_tag   = shadow_tag[LATENCY-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_valid <= '0;
      shadow_tag   <= '0;
    end else begin
      shadow_valid <= {shadow_valid[LATENCY-2:0], add_start};
      shadow_tag   <= {shadow_tag[LATENCY-2:0], start_tag_reg};
    end
  end

  // Response routing. A done with no matching head is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_inf    <= 1'b0;
      rsp_zero   <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (add_done && head_valid) begin
        rsp_valid[head_tag] <= 1'b1;
        rsp_result          <= add_result;
        rsp_inf             <= add_inf;
        rsp_zero            <= add_zero;
      end
    end
  end

  // In-flight count. The adder itself has no reset, so for LATENCY+1 cycles
  // after reset any done it raises may belong to ops issued before the
  // reset. The blank counter suppresses mismatch detection for that window.
  logic [CW-1:0] inflight_reg;
  logic [CW-1:0] blank_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_reg <= '0;
      blank_reg    <= CW'(LATENCY + 1);
      err_mismatch <= 1'b0;
    end else begin
      case ({add_start, head_valid})
        2'b10:   inflight_reg <= inflight_reg + CW'(1);
        2'b01:   inflight_reg <= inflight_reg - CW'(1);
        default: inflight_reg <= inflight_reg;
      endcase
      if (blank_reg != '0) blank_reg <= blank_reg - CW'(1);
      if (blank_reg == '0 && add_done != head_valid) err_mismatch <= 1'b1;
    end
  end

  assign busy = (inflight_reg != '0);

  // Drain FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_RUN;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN: begin
        if (drain) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!drain) state_next = ST_RUN;
        // An op sitting in add_start has not yet been counted as in flight
        else if (inflight_reg == '0 && !add_start) state_next = ST_DRAINED;
      end
      ST_DRAINED: begin
        if (!drain) state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
  end

  assign drained = (state_reg == ST_DRAINED);

endmodule

// File: tb/tb_posit_add_arbiter.sv
// tb_posit_add_arbiter
//   Randomized bench for posit_add_arbiter. It contains a stand-in adder
//   (fixed latency, no reset; the result is a plain integer sum) and a
//   transaction-level reference model: a round-robin pointer, a response
//   scoreboard keyed by due cycle, and a drain mode. Outputs are checked
//   2 ns after each rising edge.
module tb_posit_add_arbiter;

  localparam int NREQ    = 4;
  localparam int LATENCY = 8;
  localparam int DW      = 32;

  localparam int M_RUN     = 0;
  localparam int M_DRAIN   = 1;
  localparam int M_DRAINED = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ*DW-1:0] req_in1 = '0;
  logic [NREQ*DW-1:0] req_in2 = '0;
  logic [NREQ-1:0]    req_ready;
  logic [DW-1:0]      add_in1, add_in2;
  logic               add_start;
  logic [DW-1:0]      add_result;
  logic               add_inf, add_zero, add_done;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_result;
  logic               rsp_inf, rsp_zero;
  logic               drain = 1'b0;
  logic               drained, busy, err_mismatch;

  posit_add_arbiter #(.NREQ(NREQ), .LATENCY(LATENCY), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_in1(req_in1), .req_in2(req_in2), .req_ready(req_ready),
    .add_in1(add_in1), .add_in2(add_in2), .add_start(add_start),
    .add_result(add_result), .add_inf(add_inf), .add_zero(add_zero), .add_done(add_done),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_inf(rsp_inf), .rsp_zero(rsp_zero),
    .drain(drain), .drained(drained), .busy(busy), .err_mismatch(err_mismatch)
  );

  always #5 clk = ~clk;

  // Stand-in adder: samples add_start on a rising edge and raises done
  // LATENCY cycles later. It has no reset, so it keeps emitting dones for
  // ops issued before a DUT reset.
  function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
    return a + b;
  endfunction

  logic        pipe_v [LATENCY];
  logic [31:0] pipe_d [LATENCY];
  logic        stray_done = 1'b0;

  initial begin
    for (int i = 0; i < LATENCY; i++) begin
      pipe_v[i] = 1'b0;
      pipe_d[i] = '0;
    end
  end

  always @(posedge clk) begin
    pipe_v[0] <= add_start;
    pipe_d[0] <= model_add(add_in1, add_in2);
    for (int i = 1; i < LATENCY; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
  end

  assign add_done   = pipe_v[LATENCY-1] | stray_done;
  assign add_result = pipe_d[LATENCY-1];
  assign add_inf    = (add_result == 32'h8000_0000);
  assign add_zero   = (add_result == 32'h0);

  // Reference model state
  typedef struct {
    int          tag;
    logic [31:0] res;
    int          due;
  } sb_t;

  sb_t         sb[$];
  int          ptr = 0;
  int          mode = M_RUN;
  logic        prev_hs = 1'b0;
  logic [31:0] prev_a = '0, prev_b = '0;
  logic        exp_err = 1'b0;
  int          cyc = 0;
  logic        fixed_ops = 1'b0;
  logic [31:0] cur_in1 [NREQ];
  logic [31:0] cur_in2 [NREQ];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
  endtask

  // One clock cycle: drive the inputs, check every output against the
  // model, then advance the model.
  task automatic step(input logic [NREQ-1:0] v, input logic dr, input logic inj);
    logic [NREQ-1:0] exp_ready;
    int              g;
    logic            have;
    logic            bsy;
    sb_t             e;
    sb_t             ne;
    int              r;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NREQ; i++) begin
      if (fixed_ops) begin
        cur_in1[i] = 32'h4000_0000;
        cur_in2[i] = 32'h4000_0000;
      end else begin
        r = $urandom_range(0, 7);
        cur_in1[i] = $urandom;
        if (r < 2)       cur_in2[i] = -cur_in1[i];
        else if (r == 2) begin cur_in1[i] = 32'h8000_0000; cur_in2[i] = 32'h0; end
        else             cur_in2[i] = $urandom;
      end
      req_in1[i*DW +: DW] = cur_in1[i];
      req_in2[i*DW +: DW] = cur_in2[i];
    end
    req_valid  = v;
    drain      = dr;
    stray_done = inj;
    #1;

    // Expected grant
    exp_ready = '0;
    g = -1;
    if (mode == M_RUN) begin
      for (int k = 0; k < NREQ; k++) begin
        int c;
        c = (ptr + k) % NREQ;
        if (g < 0 && v[c]) g = c;
      end
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));

    chk("add_start", 32'(add_start), 32'(prev_hs));
    if (prev_hs) begin
      chk("add_in1", add_in1, prev_a);
      chk("add_in2", add_in2, prev_b);
    end

    // Expected response
    have = (sb.size() > 0) && (sb[0].due == cyc);
    if (have) begin
      e = sb.pop_front();
      chk("rsp_valid", 32'(rsp_valid), 32'(1) << e.tag);
      chk("rsp_result", rsp_result, e.res);
      chk("rsp_inf", 32'(rsp_inf), 32'(e.res == 32'h8000_0000));
      chk("rsp_zero", 32'(rsp_zero), 32'(e.res == 32'h0));
      $display("rsp cyc=%0d req=%0d result=%h", cyc, e.tag, rsp_result);
    end else begin
      chk("rsp_valid", 32'(rsp_valid), 32'h0);
    end

    // An op is in flight from two cycles after its handshake until the
    // cycle before its response.
    bsy = 1'b0;
    foreach (sb[i]) if (cyc >= sb[i].due - LATENCY) bsy = 1'b1;
    chk("busy", 32'(busy), 32'(bsy));
    chk("drained", 32'(drained), 32'(mode == M_DRAINED));
    chk("err_mismatch", 32'(err_mismatch), 32'(exp_err));

    // Advance the model
    case (mode)
      M_RUN:     if (dr) mode = M_DRAIN;
      M_DRAIN:   if (!dr) mode = M_RUN;
                 else if (!bsy && !prev_hs) mode = M_DRAINED;
      default:   if (!dr) mode = M_RUN;
    endcase
    if (inj) exp_err = 1'b1;
    if (g >= 0) begin
      ptr    = (g + 1) % NREQ;
      ne.tag = g;
      ne.res = model_add(cur_in1[g], cur_in2[g]);
      ne.due = cyc + LATENCY + 2;
      sb.push_back(ne);
      prev_a = cur_in1[g];
      prev_b = cur_in2[g];
    end
    prev_hs = (g >= 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n      = 1'b0;
    req_valid  = '0;
    drain      = 1'b0;
    stray_done = 1'b0;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_add_start", 32'(add_start), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(err_mismatch), 32'h0);
    chk("rst_drained", 32'(drained), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ptr     = 0;
    sb.delete();
    mode    = M_RUN;
    prev_hs = 1'b0;
    exp_err = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0);
  endtask

  task automatic random_phase(input int n);
    logic dr;
    dr = 1'b0;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 19) == 0) dr = ~dr;
      step(NREQ'($urandom), dr, 1'b0);
    end
  endtask

  initial begin
    do_reset();

    // Single op from requester 2
    fixed_ops = 1'b1;
    step(4'b0100, 1'b0, 1'b0);
    fixed_ops = 1'b0;
    idle(12);

    // All requesters valid continuously
    for (int i = 0; i < 12; i++) step(4'b1111, 1'b0, 1'b0);
    idle(12);

    // Requester 1 withdraws after its first op
    step(4'b1111, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(4'b1101, 1'b0, 1'b0);
    idle(12);

    // Drain after a few issues, then resume
    for (int i = 0; i < 3; i++) step(4'b1111, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(4'b1111, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(4'b1111, 1'b0, 1'b0);
    idle(12);

    random_phase(300);
    idle(12);

    // A stray done while nothing is in flight: sticky error, no response
    step('0, 1'b0, 1'b1);
    idle(3);
    random_phase(30);
    idle(12);

    // Reset with ops in flight: the adder keeps producing dones
    for (int i = 0; i < 5; i++) step(4'b1111, 1'b0, 1'b0);
    do_reset();
    idle(LATENCY + 4);
    random_phase(40);
    idle(12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
